// File: rtl/dpll_pkg.sv
// Shared definitions for the parametrised DPLL core: phase-detector modes
// and the clamp that maps kSel onto the usable K-counter exponent range.
package dpll_pkg;

    typedef enum logic {
        PD_XOR = 1'b0,
        PD_JK  = 1'b1
    } pd_mode_t;

    localparam int unsigned K_MIN = 2;

    function automatic logic [4:0] k_eff(input logic [4:0] ksel, input int unsigned kmax);
        if (32'(ksel) < K_MIN) return 5'(K_MIN);
        if (32'(ksel) > kmax)  return 5'(kmax);
        return ksel;
    endfunction

endpackage

// File: rtl/dpll_kcounter.sv
// K-counter loop filter: up/down counter of modulus 2^keff that reloads its
// midpoint on wrap, after reset and whenever the effective modulus changes.
module dpll_kcounter #(
    parameter int unsigned K_WIDTH = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_up,
    input  logic [4:0]         i_keff,
    output logic [K_WIDTH-1:0] o_count,
    output logic               o_carry,
    output logic               o_borrow
);

    logic [K_WIDTH-1:0] r_count;
    logic [K_WIDTH-1:0] w_mid;
    logic [K_WIDTH-1:0] w_max;
    logic [4:0]         r_keff;
    logic               r_reload;
    logic               r_carry;
    logic               r_borrow;

    // At keff == K_WIDTH the shifted midpoint overflows to 0, so max becomes all ones.
    always_comb begin
        w_mid = K_WIDTH'(1) << (i_keff - 5'd1);
        w_max = (w_mid << 1) - K_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_keff   <= '0;
            r_reload <= 1'b1;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_keff   <= i_keff;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            if (r_reload || (i_keff != r_keff)) begin
                r_count  <= w_mid;
                r_reload <= 1'b0;
            end else if (i_up) begin
                if (r_count == w_max) begin
                    r_count <= w_mid;
                    r_carry <= 1'b1;
                end else begin
                    r_count <= r_count + K_WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    r_count  <= w_mid;
                    r_borrow <= 1'b1;
                end else begin
                    r_count <= r_count - K_WIDTH'(1);
                end
            end
        end
    end

    assign o_count  = r_count & w_max;
    assign o_carry  = r_carry;
    assign o_borrow = r_borrow;

endmodule

// File: rtl/dpll_core_param.sv
// All-digital PLL core: synchroniser, XOR/JK phase detector, K-counter filter,
// increment/decrement DCO, divide-by-N feedback and a quiet-period lock detector.
module dpll_core_param
    import dpll_pkg::*;
#(
    parameter int unsigned K_WIDTH     = 20,
    parameter int unsigned DIV_N       = 8,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned LOCK_TOL    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               baseClockInput,
    input  logic               reset,
    input  logic               oscInput,
    input  logic               pdMode,
    input  logic [4:0]         kSel,
    output logic               dpdOut,
    output logic               dlfCarry,
    output logic               dlfBorrow,
    output logic               inc,
    output logic               dec,
    output logic               DCOout,
    output logic               dpllOutput,
    output logic               locked,
    output logic [K_WIDTH-1:0] counter
);

    localparam int unsigned HALF_N = DIV_N / 2;
    localparam int unsigned DIV_W  = (HALF_N > 1) ? $clog2(HALF_N) : 1;
    localparam int unsigned LCK_W  = $clog2(LOCK_CNT + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_refPrev;
    logic                   r_fbPrev;
    logic                   r_dpd;
    logic                   r_inc;
    logic                   r_dec;
    logic [1:0]             r_idCnt;
    logic                   r_dcoPrev;
    logic [DIV_W-1:0]       r_div;
    logic                   r_dpll;
    logic [1:0]             r_corr;
    logic [LCK_W-1:0]       r_quiet;
    logic                   r_locked;

    logic       w_refS;
    logic       w_refRise;
    logic       w_fbRise;
    logic       w_dcoRise;
    logic       w_carry;
    logic       w_borrow;
    logic       w_corr;
    logic [4:0] w_keff;

    assign w_keff    = k_eff(kSel, K_WIDTH);
    assign w_refS    = r_sync[SYNC_STAGES-1];
    assign w_refRise = w_refS & ~r_refPrev;
    assign w_fbRise  = r_dpll & ~r_fbPrev;
    assign w_dcoRise = r_idCnt[1] & ~r_dcoPrev;
    assign w_corr    = w_carry | w_borrow;

    dpll_kcounter #(.K_WIDTH(K_WIDTH)) u_kcounter (
        .clk      (baseClockInput),
        .rst_n    (reset),
        .i_up     (r_dpd),
        .i_keff   (w_keff),
        .o_count  (counter),
        .o_carry  (w_carry),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge baseClockInput or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_refPrev <= 1'b0;
            r_fbPrev  <= 1'b0;
            r_dpd     <= 1'b0;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_idCnt   <= '0;
            r_dcoPrev <= 1'b0;
            r_div     <= '0;
            r_dpll    <= 1'b0;
            r_corr    <= '0;
            r_quiet   <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], oscInput};
            r_refPrev <= w_refS;
            r_fbPrev  <= r_dpll;

            if (pd_mode_t'(pdMode) == PD_JK) begin
                if (w_refRise)     r_dpd <= 1'b1;
                else if (w_fbRise) r_dpd <= 1'b0;
            end else begin
                r_dpd <= w_refS ^ r_dpll;
            end

            r_inc   <= w_carry;
            r_dec   <= w_borrow;
            r_idCnt <= r_idCnt + (r_dec ? 2'd0 : (r_inc ? 2'd2 : 2'd1));

            r_dcoPrev <= r_idCnt[1];
            if (w_dcoRise) begin
                if (32'(r_div) == HALF_N - 1) begin
                    r_div  <= '0;
                    r_dpll <= ~r_dpll;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end

            // A correction landing on the refRise cycle opens the next period's tally.
            if (w_refRise) begin
                r_corr <= w_corr ? 2'd1 : 2'd0;
                if (32'(r_corr) <= LOCK_TOL) begin
                    if (32'(r_quiet) != LOCK_CNT) r_quiet <= r_quiet + LCK_W'(1);
                    r_locked <= (32'(r_quiet) + 1 >= LOCK_CNT);
                end else begin
                    r_quiet  <= '0;
                    r_locked <= 1'b0;
                end
            end else if (w_corr && (r_corr != 2'd3)) begin
                r_corr <= r_corr + 2'd1;
            end
        end
    end

    assign dpdOut     = r_dpd;
    assign dlfCarry   = w_carry;
    assign dlfBorrow  = w_borrow;
    assign inc        = r_inc;
    assign dec        = r_dec;
    assign DCOout     = r_idCnt[1];
    assign dpllOutput = r_dpll;
    assign locked     = r_locked;

endmodule
